// File: rtl/costas_acq_ctrl.sv
// costas_acq_ctrl: Costas loop acquisition sweep and windowed lock controller
// Ports:
//   clk, reset_n      8 MHz clock, synchronous active-low reset
//   start, abort      acquisition start pulse; abort level forces IDLE
//   di, dq            signed 26-bit phase-detector low-pass outputs
//   carrier           registered NCO centre phase increment
//   loop_clr          loop-filter integrator clear
//   gain_sel          loop-filter gear, 0 = wide, 1 = narrow
//   locked            lock flag
//   sweep_wrap        one-cycle pulse when every bin has failed
//   state             FSM state encoding
// Define ACQ_SWEEP_EN to enable the frequency-bin sweep; otherwise k stays 0.
module costas_acq_ctrl #(
  parameter logic [29:0] CENTER_WORD = 30'd268435456,
  parameter logic [29:0] STEP_WORD = 30'd268435,
  parameter int MAX_BIN = 4,
  parameter int WIN_LOG2 = 10,
  parameter logic [25:0] LOCK_TH = 26'd1048576,
  parameter int SETTLE_CYC = 4096,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 2
) (
  input logic clk,
  input logic reset_n,
  input logic start,
  input logic abort,
  input logic signed [25:0] di,
  input logic signed [25:0] dq,
  output logic [29:0] carrier,
  output logic loop_clr,
  output logic gain_sel,
  output logic locked,
  output logic sweep_wrap,
  output logic [2:0] state
);
  localparam int AW = 27 + WIN_LOG2;
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int PW = $clog2(LOCK_CNT + 1);
  localparam int FW = $clog2(LOSS_CNT + 1);
  localparam logic signed [AW-1:0] TH = AW'(LOCK_TH);
  typedef enum logic [2:0] {
    IDLE = 3'd0, CLEAR = 3'd1, SETTLE = 3'd2, DWELL = 3'd3, LOCKED = 3'd4, NEXT_BIN = 3'd5
  } state_t;
`ifdef ACQ_SWEEP_EN
  localparam state_t FAIL_ST = NEXT_BIN;
`else
  localparam state_t FAIL_ST = CLEAR;
`endif
  state_t st, st_nx;
  logic [SW-1:0] scnt;
  logic [WIN_LOG2-1:0] wcnt;
  logic [PW-1:0] pcnt;
  logic [FW-1:0] fcnt;
  logic signed [AW-1:0] acc, acc_sum, mean;
  logic signed [26:0] e;
  logic win_end, pass, in_win;
  // |x| with the most negative code saturating so it fits the 26-bit magnitude
  function automatic logic [25:0] mag(input logic signed [25:0] x);
    return x == {1'b1, 25'd0} ? 26'h1ffffff : x[25] ? 26'(-x) : x;
  endfunction
  assign state = st;
  assign e = $signed({1'b0, mag(di)}) - $signed({1'b0, mag(dq)});
  // Window decision uses the sum including the current (last) sample
  assign acc_sum = acc + AW'(e);
  assign mean = acc_sum >>> WIN_LOG2;
  assign pass = mean > TH;
  assign in_win = st == DWELL || st == LOCKED;
  assign win_end = in_win && wcnt == '1;
  always_comb begin
    st_nx = st;
    case (st)
      IDLE: st_nx = start ? CLEAR : IDLE;
      CLEAR: st_nx = SETTLE;
      SETTLE: st_nx = scnt == SW'(SETTLE_CYC - 1) ? DWELL : SETTLE;
      DWELL: st_nx = !win_end ? DWELL : !pass ? FAIL_ST : pcnt == PW'(LOCK_CNT - 1) ? LOCKED : DWELL;
      LOCKED: st_nx = win_end && !pass && fcnt == FW'(LOSS_CNT - 1) ? CLEAR : LOCKED;
      NEXT_BIN: st_nx = CLEAR;
      default: st_nx = IDLE;
    endcase
    if (abort) st_nx = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st <= IDLE;
      scnt <= '0;
      wcnt <= '0;
      acc <= '0;
      pcnt <= '0;
      fcnt <= '0;
      loop_clr <= 1'b1;
      gain_sel <= 1'b0;
      locked <= 1'b0;
    end else begin
      st <= st_nx;
      scnt <= st == SETTLE ? scnt + 1'b1 : '0;
      // Window restarts on any state change, including DWELL -> LOCKED
      if (!in_win || st_nx != st || win_end) begin
        wcnt <= '0;
        acc <= '0;
      end else begin
        wcnt <= wcnt + 1'b1;
        acc <= acc_sum;
      end
      pcnt <= st != DWELL ? '0 : win_end && pass ? pcnt + 1'b1 : pcnt;
      fcnt <= st != LOCKED ? '0 : !win_end ? fcnt : pass ? '0 : fcnt + 1'b1;
      loop_clr <= st_nx == IDLE || st_nx == CLEAR;
      gain_sel <= st_nx == LOCKED;
      locked <= st_nx == LOCKED;
    end
  end
`ifdef ACQ_SWEEP_EN
  localparam logic signed [3:0] MB = 4'(MAX_BIN);
  logic signed [3:0] k, k_nx;
  logic signed [34:0] off;
  logic adv, wrap_nx;
  // Sweep order 0, +1, -1, +2, -2, ..., +MAX_BIN, -MAX_BIN, 0
  always_comb begin
    adv = st == NEXT_BIN && st_nx == CLEAR;
    wrap_nx = adv && k == -MB;
    k_nx = st_nx == IDLE ? 4'sd0 : !adv ? k : k > 0 ? -k : k == -MB ? 4'sd0 : 4'sd1 - k;
    off = 35'(k_nx) * $signed(35'(STEP_WORD));
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      k <= '0;
      carrier <= CENTER_WORD;
      sweep_wrap <= 1'b0;
    end else begin
      k <= k_nx;
      carrier <= CENTER_WORD + off[29:0];
      sweep_wrap <= wrap_nx;
    end
  end
`else
  always_ff @(posedge clk) begin
    carrier <= CENTER_WORD;
    sweep_wrap <= 1'b0;
  end
`endif
endmodule

// File: tb/tb_costas_acq_ctrl.sv
// tb_costas_acq_ctrl: directed self-checking bench for costas_acq_ctrl
module tb_costas_acq_ctrl;
  logic clk = 1'b0;
  logic reset_n, start, abort;
  logic signed [25:0] di, dq;
  logic [29:0] carrier;
  logic loop_clr, gain_sel, locked, sweep_wrap;
  logic [2:0] state;
  int checks = 0;
  int failures = 0;
  int wraps = 0;
  costas_acq_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .di(di), .dq(dq),
    .carrier(carrier), .loop_clr(loop_clr), .gain_sel(gain_sel), .locked(locked),
    .sweep_wrap(sweep_wrap), .state(state)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (reset_n && sweep_wrap) wraps++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask
  task automatic do_abort();
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
  endtask
  localparam logic [29:0] CENTER = 30'd268435456;
  int ks[9] = '{1, -1, 2, -2, 3, -3, 4, -4, 0};
  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    di = 26'sd4194304;
    dq = 26'sd0;
    tick(3);
    check("rst_state", state, 0);
    check("rst_carrier", carrier, CENTER);
    check("rst_loop_clr", loop_clr, 1);
    check("rst_gain_sel", gain_sel, 0);
    check("rst_locked", locked, 0);
    check("rst_wrap", sweep_wrap, 0);
    reset_n = 1'b1;
    tick(1);
    start = 1'b1;
    abort = 1'b1;
    tick(1);
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_state", state, 0);
    check("abort_start_clr", loop_clr, 1);
    pulse_start();
    check("clear_state", state, 1);
    check("clear_loop_clr", loop_clr, 1);
    tick(10);
    check("settle_state", state, 2);
    do_abort();
    check("abort_settle_state", state, 0);
    check("abort_settle_clr", loop_clr, 1);
    pulse_start();
    check("clear2_state", state, 1);
    tick(1);
    check("settle_entry", state, 2);
    check("settle_clr", loop_clr, 0);
    tick(4095);
    check("settle_end", state, 2);
    tick(1);
    check("dwell_entry", state, 3);
    check("dwell_gain", gain_sel, 0);
    tick(4095);
    check("pre_lock_state", state, 3);
    check("pre_lock_locked", locked, 0);
    tick(1);
    check("lock_state", state, 4);
    check("lock_locked", locked, 1);
    check("lock_gain", gain_sel, 1);
    check("lock_carrier", carrier, CENTER);
    dq = di;
    tick(1024);
    check("one_fail_state", state, 4);
    check("one_fail_locked", locked, 1);
    tick(1024);
    check("loss_state", state, 1);
    check("loss_locked", locked, 0);
    check("loss_clr", loop_clr, 1);
    check("loss_carrier", carrier, CENTER);
`ifdef ACQ_SWEEP_EN
    for (int i = 0; i < 9; i++) begin
      tick(i == 0 ? 5121 : 5120);
      check("nb_state", state, 5);
      tick(1);
      check("nb_clear", state, 1);
      check("nb_carrier", carrier, 30'(268435456 + ks[i] * 268435));
      check("nb_clr", loop_clr, 1);
      check("nb_wrap", sweep_wrap, i == 8);
      tick(1);
      check("nb_clr_off", loop_clr, 0);
    end
    check("wrap_count", wraps, 1);
`else
    tick(5121);
    check("fail_clear", state, 1);
    check("fail_carrier", carrier, CENTER);
    check("fail_clr", loop_clr, 1);
    tick(1);
    check("fail_clr_off", loop_clr, 0);
    check("wrap_count", wraps, 0);
`endif
    di = {1'b1, 25'd0};
    dq = 26'sd0;
    tick(8191);
    check("sat_dwell", state, 3);
    tick(1);
    check("sat_locked_state", state, 4);
    check("sat_locked", locked, 1);
    do_abort();
    check("abort_lock_state", state, 0);
    check("abort_lock_locked", locked, 0);
    check("abort_lock_clr", loop_clr, 1);
    check("abort_lock_gain", gain_sel, 0);
    check("abort_lock_carrier", carrier, CENTER);
    di = 26'sd1048576;
    pulse_start();
    tick(5120);
    check("eq_th_dwell", state, 3);
    tick(1);
`ifdef ACQ_SWEEP_EN
    check("eq_th_fail", state, 5);
`else
    check("eq_th_fail", state, 1);
`endif
    do_abort();
    check("abort_eq_state", state, 0);
    di = 26'sd1048577;
    pulse_start();
    tick(5121);
    check("above_th_pass", state, 3);
    tick(3072);
    check("above_th_lock", state, 4);
    check("wrap_total", wraps, `ifdef ACQ_SWEEP_EN 1 `else 0 `endif);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
